calculator_core: RTL and testbench
==================================

Name: calculator_core

Overview:
- Parametrised successor to the 4-digit hex keypad calculator.
- Accepts debounced keypad events (newkey strobe plus 5-bit keycode) and maintains a sign-magnitude accumulator and an entry register, NDIG hex digits wide.
- Adds a sequential shift-add multiplier with a busy/key_drop handshake and repeat-equals (a repeated = re-applies the last operation).
- Sits between the keypad scanner and the display driver.

Parameters:
- NDIG, 4, number of hex digits; data width W = 4*NDIG (NDIG 2..8).

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- newkey  input  1  one-cycle key strobe; keycode sampled only on a clock edge where newkey=1.
- keycode  input  5  bit4=1: hex digit in [3:0]; bit4=0: command in [3:0]. Commands: ADD=A, MULT=2, SUBT=3, EQLS=4, BACK=1, CLEAR=9, CLRE=C. Other command codes are ignored.
- value  output  W  displayed magnitude.
- sign  output  1  displayed sign, 1 = negative.
- ovw  output  1  overflow of the last result.
- busy  output  1  multiplier running.
- key_drop  output  1  one-cycle pulse when a key is discarded because busy=1.

Behaviour:
- Reset (reset=0 at a clock edge): acc, entry, operand2 = 0; signs 0; pending op = ADD; state ENTRY1; value=0, sign=0, ovw=0, busy=0, key_drop=0. Reset overrides all activity, including a multiply in progress.
- Registers:
  - acc: sign + W bits.
  - entry: W bits, always positive.
  - op: last operator.
  - opnd2: sign + W bits, last second operand, kept for repeat-equals.
- States: ENTRY1, OPWAIT, ENTRY2, CALC, RESULT.
- Display: ENTRY1 and ENTRY2 show entry with sign=0. OPWAIT, CALC and RESULT show acc.
- Digit key:
  - In ENTRY1 or ENTRY2: entry <= {entry[W-5:0], digit}, visible the cycle after the strobe. Ignored if entry[W-1:W-4] != 0 (entry already full).
  - In OPWAIT: entry <= digit; go to ENTRY2.
  - In RESULT: acc <= 0, ovw <= 0, entry <= digit; go to ENTRY1.
- BACK:
  - In entry states: entry <= entry >> 4.
  - In RESULT: entry <= acc magnitude >> 4, ovw <= 0; go to ENTRY1. Example: result 5A becomes 5.
  - In OPWAIT: no effect.
- CLRE: entry <= 0; state and op unchanged. In RESULT it behaves as CLEAR.
- CLEAR: identical to the reset state.
- Operator (ADD, SUBT, MULT):
  - In ENTRY1: acc <= +entry, op <= key; go to OPWAIT.
  - In OPWAIT: op replaced.
  - In RESULT: op <= key, acc kept; go to OPWAIT.
  - In ENTRY2 (chaining): opnd2 <= +entry, compute acc op opnd2, then op <= new key and land in OPWAIT.
- EQLS:
  - In ENTRY2: opnd2 <= +entry.
  - In OPWAIT: opnd2 <= acc. So "5 + =" gives A and "5 x =" gives 19.
  - In RESULT: opnd2 unchanged, which gives repeat-equals.
  - In ENTRY1: acc <= +entry; go to RESULT with no arithmetic.
  - In every case except ENTRY1, compute acc op opnd2 and land in RESULT.
- Arithmetic:
  - Signed sign-magnitude; subtraction is acc + (-opnd2).
  - Magnitudes are compared to select the result sign.
  - A zero result always has sign=0.
  - Product sign is the XOR of the operand signs.
  - ovw=1 if the true magnitude is >= 2^W; value then holds the low W bits.
  - ovw is held until a digit in RESULT, BACK in RESULT, CLEAR, or reset. A subsequent non-overflowing compute clears it.
- Latency, add/subtract: one compute cycle. The result is visible 2 clock edges after the strobe edge; busy stays 0.
- Latency, multiply:
  - Enter CALC; busy=1 from the edge after the strobe for exactly W cycles. One multiplier bit per cycle; 2W-bit partial product.
  - On the final cycle the result is written, busy drops, and the state becomes RESULT (or OPWAIT when chaining).
- Keys during busy=1: discarded, with key_drop=1 for exactly the cycle after the strobe edge; no state change.
- A newkey strobe in the same cycle as the add/subtract compute cycle is also dropped and pulses key_drop.
- Back-to-back strobes on consecutive edges when not busy: each is processed in order.

Test Plan:
- NDIG=4: keys D, SUBT, F, EQLS -> sign=1, value=0002, ovw=0. A further EQLS -> sign=1, value=0011. A further EQLS -> sign=1, value=0020.
- NDIG=4: FFFF MULT 2 EQLS -> busy high for exactly 16 cycles, then value=FFFE, ovw=1. Digit 3 -> value=0003, ovw=0.
- NDIG=4: during the multiply 1234 MULT 3 EQLS, strobe digit 7 while busy -> one key_drop pulse; final value=369C, sign=0. Display never shows 7.
- NDIG=4: 5 5 5 BACK BACK -> 0005. 55 ADD 5 EQLS -> 005A. BACK -> 0005. CLEAR -> 0000. 5 ADD 4 CLRE 3 EQLS -> 0008. Digits 1 2 3 4 5 -> 1234 (fifth digit ignored).
- NDIG=6: FFFFFF ADD 1 EQLS -> value=000000, ovw=1, sign=0. 3 SUBT 5 SUBT 2 EQLS (chain) -> sign=1, value=000004.
- Reset mid-multiply: drive reset=0 for one edge at multiply cycle 5 -> next cycle all outputs 0, busy=0, state ENTRY1. Then 2 ADD 2 EQLS -> 0004.

Source files
------------

// File: rtl/calculator_core.sv
// =============================================================================
// calculator_core : sign-magnitude hex keypad calculator with shift-add multiply
// Revision        : 1.0
// =============================================================================
`default_nettype none

module calculator_core #(
  parameter int NDIG = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              newkey,
  input  logic [4:0]        keycode,
  output logic [4*NDIG-1:0] value,
  output logic              sign,
  output logic              ovw,
  output logic              busy,
  output logic              key_drop
);

  localparam int W  = 4 * NDIG;
  localparam int CW = $clog2(W);

  localparam logic [2:0] S_ENTRY1 = 3'd0;
  localparam logic [2:0] S_OPWAIT = 3'd1;
  localparam logic [2:0] S_ENTRY2 = 3'd2;
  localparam logic [2:0] S_CALC   = 3'd3;
  localparam logic [2:0] S_RESULT = 3'd4;

  localparam logic [3:0] K_BACK  = 4'h1;
  localparam logic [3:0] K_MULT  = 4'h2;
  localparam logic [3:0] K_SUBT  = 4'h3;
  localparam logic [3:0] K_EQLS  = 4'h4;
  localparam logic [3:0] K_CLEAR = 4'h9;
  localparam logic [3:0] K_ADD   = 4'hA;
  localparam logic [3:0] K_CLRE  = 4'hC;

  logic [2:0]    state, next_state;
  logic          acc_s, o2_s;
  logic [W-1:0]  acc_m, o2_m, entry;
  logic [3:0]    op, next_op;
  logic          is_mul, chain;
  logic [2*W-1:0] mcand, prod;
  logic [W-1:0]  mplier;
  logic [CW-1:0] cnt;

  logic [3:0]    cmd;
  logic          accept, is_digit, is_op, is_eq, is_back, is_clear, is_clre, do_clear;
  logic          entry_full, calc_done;
  logic [W-1:0]  src_m;
  logic          src_s;
  logic [W:0]    sum;
  logic          b_s, as_sign, as_ovw;
  logic [W-1:0]  as_mag;
  logic [2*W-1:0] prod_next;
  logic [W-1:0]  res_m;
  logic          res_s, res_ovw;

  assign cmd        = keycode[3:0];
  assign accept     = newkey && (state != S_CALC);
  assign is_digit   = keycode[4];
  assign is_op      = !keycode[4] && (cmd == K_ADD || cmd == K_MULT || cmd == K_SUBT);
  assign is_eq      = !keycode[4] && (cmd == K_EQLS);
  assign is_back    = !keycode[4] && (cmd == K_BACK);
  assign is_clear   = !keycode[4] && (cmd == K_CLEAR);
  assign is_clre    = !keycode[4] && (cmd == K_CLRE);
  assign do_clear   = is_clear || (is_clre && state == S_RESULT);
  assign entry_full = |entry[W-1:W-4];
  assign calc_done  = !is_mul || (cnt == CW'(W - 1));

  // Second operand captured on the compute-starting key: entry, acc, or the kept one.
  always_comb begin
    src_m = o2_m;
    src_s = o2_s;
    if (state == S_ENTRY2) begin
      src_m = entry;
      src_s = 1'b0;
    end else if (state == S_OPWAIT) begin
      src_m = acc_m;
      src_s = acc_s;
    end
  end

  always_comb begin
    b_s     = o2_s ^ (op == K_SUBT);
    sum     = {1'b0, acc_m} + {1'b0, o2_m};
    as_ovw  = 1'b0;
    as_sign = acc_s;
    as_mag  = sum[W-1:0];
    if (acc_s == b_s) begin
      as_ovw = sum[W];
    end else if (acc_m >= o2_m) begin
      as_mag = acc_m - o2_m;
    end else begin
      as_mag  = o2_m - acc_m;
      as_sign = b_s;
    end
  end

  assign prod_next = prod + (mplier[0] ? mcand : '0);

  always_comb begin
    res_m   = is_mul ? prod_next[W-1:0] : as_mag;
    res_ovw = is_mul ? |prod_next[2*W-1:W] : as_ovw;
    res_s   = (res_m == '0) ? 1'b0 : (is_mul ? (acc_s ^ o2_s) : as_sign);
  end

  always_ff @(posedge clock) begin
    if (!reset) state <= S_ENTRY1;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_ENTRY1: if (accept) begin
        if (is_op)      next_state = S_OPWAIT;
        else if (is_eq) next_state = S_RESULT;
      end
      S_OPWAIT: if (accept) begin
        if (is_clear)      next_state = S_ENTRY1;
        else if (is_digit) next_state = S_ENTRY2;
        else if (is_eq)    next_state = S_CALC;
      end
      S_ENTRY2: if (accept) begin
        if (is_clear)            next_state = S_ENTRY1;
        else if (is_op || is_eq) next_state = S_CALC;
      end
      S_RESULT: if (accept) begin
        if (is_clear || is_clre || is_digit || is_back) next_state = S_ENTRY1;
        else if (is_op) next_state = S_OPWAIT;
        else if (is_eq) next_state = S_CALC;
      end
      S_CALC: if (calc_done) next_state = chain ? S_OPWAIT : S_RESULT;
      default: next_state = S_ENTRY1;
    endcase
  end

  always_comb begin
    busy  = (state == S_CALC) && is_mul;
    value = acc_m;
    sign  = acc_s;
    if (state == S_ENTRY1 || state == S_ENTRY2) begin
      value = entry;
      sign  = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      acc_m <= '0;  acc_s <= 1'b0;  entry <= '0;
      o2_m  <= '0;  o2_s  <= 1'b0;  op    <= K_ADD;
      next_op <= K_ADD;  is_mul <= 1'b0;  chain <= 1'b0;
      mcand <= '0;  mplier <= '0;  prod <= '0;  cnt <= '0;
      ovw   <= 1'b0;  key_drop <= 1'b0;
    end else begin
      key_drop <= newkey && (state == S_CALC);
      if (state == S_CALC) begin
        if (is_mul) begin
          prod   <= prod_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
        end
        if (calc_done) begin
          acc_m <= res_m;
          acc_s <= res_s;
          ovw   <= res_ovw;
          if (chain) op <= next_op;
        end
      end else if (accept) begin
        if (do_clear) begin
          acc_m <= '0;  acc_s <= 1'b0;  entry <= '0;
          o2_m  <= '0;  o2_s  <= 1'b0;  op    <= K_ADD;
          ovw   <= 1'b0;
        end else if (is_digit) begin
          case (state)
            S_ENTRY1, S_ENTRY2: if (!entry_full) entry <= {entry[W-5:0], cmd};
            S_OPWAIT: entry <= {{(W-4){1'b0}}, cmd};
            S_RESULT: begin
              acc_m <= '0;
              acc_s <= 1'b0;
              ovw   <= 1'b0;
              entry <= {{(W-4){1'b0}}, cmd};
            end
            default: ;
          endcase
        end else if (is_back) begin
          if (state == S_ENTRY1 || state == S_ENTRY2) begin
            entry <= entry >> 4;
          end else if (state == S_RESULT) begin
            entry <= acc_m >> 4;
            ovw   <= 1'b0;
          end
        end else if (is_clre) begin
          entry <= '0;
        end else if (is_op || is_eq) begin
          if (state == S_ENTRY1) begin
            acc_m <= entry;
            acc_s <= 1'b0;
            if (is_op) op <= cmd;
          end else if (is_op && state != S_ENTRY2) begin
            op <= cmd;
          end else begin
            // Start a compute with the pending operator; chaining lands in OPWAIT.
            o2_m    <= src_m;
            o2_s    <= src_s;
            chain   <= is_op;
            next_op <= cmd;
            is_mul  <= (op == K_MULT);
            prod    <= '0;
            mcand   <= {{W{1'b0}}, acc_m};
            mplier  <= src_m;
            cnt     <= '0;
          end
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_calculator_core.sv
// =============================================================================
// tb_calculator_core : vector table, corner sequences and random model check
// Revision           : 1.0
// =============================================================================
`default_nettype none

module tb_calculator_core;

  localparam logic [4:0] ADD = 5'h0A, MULT = 5'h02, SUBT = 5'h03, EQLS = 5'h04;
  localparam logic [4:0] BACK = 5'h01, CLEAR = 5'h09, CLRE = 5'h0C;

  logic clk = 1'b0;
  logic rst_n;
  logic nk4, nk6;
  logic [4:0] kc4, kc6;
  logic [15:0] v4;
  logic [23:0] v6;
  logic s4, o4, b4, d4, s6, o6, b6, d6;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  calculator_core #(.NDIG(4)) dut4 (
    .clock(clk), .reset(rst_n), .newkey(nk4), .keycode(kc4),
    .value(v4), .sign(s4), .ovw(o4), .busy(b4), .key_drop(d4));

  calculator_core #(.NDIG(6)) dut6 (
    .clock(clk), .reset(rst_n), .newkey(nk6), .keycode(kc6),
    .value(v6), .sign(s6), .ovw(o6), .busy(b6), .key_drop(d6));

  typedef struct {
    logic [4:0]  key;
    logic [15:0] val;
    logic        sgn;
    logic        ov;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [4:0] dg(input logic [3:0] d);
    return {1'b1, d};
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int s, input logic n, input logic [4:0] k);
    if (s == 0) begin nk4 = n; kc4 = k; end
    else        begin nk6 = n; kc6 = k; end
  endtask

  task automatic press(input int s, input logic [4:0] k);
    @(negedge clk);
    drive(s, 1'b1, k);
    @(negedge clk);
    drive(s, 1'b0, 5'h00);
  endtask

  task automatic key(input int s, input logic [4:0] k);
    int n;
    press(s, k);
    n = 0;
    while (((s == 0) ? b4 : b6) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("busy_timeout", n, 0);
    @(negedge clk);
  endtask

  task automatic tv(input logic [4:0] k, input logic [15:0] v, input logic s, input logic o);
    vec_t e;
    e.key = k; e.val = v; e.sgn = s; e.ov = o;
    tbl.push_back(e);
  endtask

  // Behavioural model: calculator modes, signed integer arithmetic on magnitudes.
  localparam int M_E1 = 0, M_OW = 1, M_E2 = 2, M_RES = 3;
  localparam longint MASK = 64'hFFFF;
  int     m_mode;
  longint m_entry, m_acc, m_o2;
  logic   m_acc_s, m_o2_s, m_ovw;
  logic [4:0] m_op;

  task automatic m_clear();
    m_mode = M_E1; m_entry = 0; m_acc = 0; m_o2 = 0;
    m_acc_s = 0; m_o2_s = 0; m_ovw = 0; m_op = ADD;
  endtask

  task automatic m_compute();
    longint a, b, r, mag;
    a = m_acc_s ? -m_acc : m_acc;
    b = m_o2_s ? -m_o2 : m_o2;
    if (m_op == SUBT) b = -b;
    r = (m_op == MULT) ? a * b : a + b;
    mag = (r < 0) ? -r : r;
    m_ovw = (mag > MASK);
    m_acc = mag & MASK;
    m_acc_s = (m_acc != 0) && (r < 0);
  endtask

  task automatic m_key(input logic [4:0] k);
    if (k[4]) begin
      case (m_mode)
        M_E1, M_E2: if (m_entry < 64'h1000) m_entry = m_entry * 16 + k[3:0];
        M_OW: begin m_entry = k[3:0]; m_mode = M_E2; end
        default: begin m_acc = 0; m_acc_s = 0; m_ovw = 0; m_entry = k[3:0]; m_mode = M_E1; end
      endcase
    end else if (k == CLEAR || (k == CLRE && m_mode == M_RES)) begin
      m_clear();
    end else if (k == CLRE) begin
      m_entry = 0;
    end else if (k == BACK) begin
      if (m_mode == M_E1 || m_mode == M_E2) m_entry = m_entry / 16;
      else if (m_mode == M_RES) begin m_entry = m_acc / 16; m_ovw = 0; m_mode = M_E1; end
    end else if (k == ADD || k == SUBT || k == MULT) begin
      if (m_mode == M_E1) begin m_acc = m_entry; m_acc_s = 0; end
      else if (m_mode == M_E2) begin m_o2 = m_entry; m_o2_s = 0; m_compute(); end
      m_op = k;
      m_mode = M_OW;
    end else if (k == EQLS) begin
      if (m_mode == M_E1) begin
        m_acc = m_entry; m_acc_s = 0;
      end else begin
        if (m_mode == M_E2) begin m_o2 = m_entry; m_o2_s = 0; end
        else if (m_mode == M_OW) begin m_o2 = m_acc; m_o2_s = m_acc_s; end
        m_compute();
      end
      m_mode = M_RES;
    end
  endtask

  function automatic logic [4:0] rand_key();
    int r;
    r = $urandom_range(0, 15);
    if (r <= 6) return dg(4'($urandom_range(0, 15)));
    case (r)
      7:  return ADD;
      8:  return SUBT;
      9:  return MULT;
      10, 11: return EQLS;
      12: return BACK;
      13: return CLRE;
      14: return CLEAR;
      default: begin
        case ($urandom_range(0, 3))
          0: return 5'h00;
          1: return 5'h05;
          2: return 5'h0E;
          default: return 5'h0F;
        endcase
      end
    endcase
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, drops, seen7;
    logic [15:0] ev;
    logic es;

    rst_n = 1'b0; nk4 = 1'b0; nk6 = 1'b0; kc4 = '0; kc6 = '0;
    repeat (3) @(negedge clk);
    check("rst_value", v4, 0);
    check("rst_sign", s4, 0);
    check("rst_ovw", o4, 0);
    check("rst_busy", b4, 0);
    check("rst_drop", d4, 0);
    check("rst_value6", v6, 0);
    rst_n = 1'b1;

    tv(dg(4'hD), 16'h000D, 0, 0); tv(SUBT, 16'h000D, 0, 0); tv(dg(4'hF), 16'h000F, 0, 0);
    tv(EQLS, 16'h0002, 1, 0); tv(EQLS, 16'h0011, 1, 0); tv(EQLS, 16'h0020, 1, 0);
    tv(CLEAR, 16'h0000, 0, 0);
    tv(dg(5), 16'h0005, 0, 0); tv(dg(5), 16'h0055, 0, 0); tv(dg(5), 16'h0555, 0, 0);
    tv(BACK, 16'h0055, 0, 0); tv(BACK, 16'h0005, 0, 0); tv(CLEAR, 16'h0000, 0, 0);
    tv(dg(5), 16'h0005, 0, 0); tv(dg(5), 16'h0055, 0, 0); tv(ADD, 16'h0055, 0, 0);
    tv(dg(5), 16'h0005, 0, 0); tv(EQLS, 16'h005A, 0, 0); tv(BACK, 16'h0005, 0, 0);
    tv(CLEAR, 16'h0000, 0, 0);
    tv(dg(5), 16'h0005, 0, 0); tv(ADD, 16'h0005, 0, 0); tv(dg(4), 16'h0004, 0, 0);
    tv(CLRE, 16'h0000, 0, 0); tv(dg(3), 16'h0003, 0, 0); tv(EQLS, 16'h0008, 0, 0);
    tv(CLEAR, 16'h0000, 0, 0);
    tv(dg(1), 16'h0001, 0, 0); tv(dg(2), 16'h0012, 0, 0); tv(dg(3), 16'h0123, 0, 0);
    tv(dg(4), 16'h1234, 0, 0); tv(dg(5), 16'h1234, 0, 0); tv(5'h05, 16'h1234, 0, 0);
    tv(CLEAR, 16'h0000, 0, 0);
    tv(dg(5), 16'h0005, 0, 0); tv(MULT, 16'h0005, 0, 0); tv(EQLS, 16'h0019, 0, 0);
    tv(CLEAR, 16'h0000, 0, 0);
    tv(dg(5), 16'h0005, 0, 0); tv(ADD, 16'h0005, 0, 0); tv(EQLS, 16'h000A, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      key(0, tbl[i].key);
      check($sformatf("tbl%0d_value", i), v4, tbl[i].val);
      check($sformatf("tbl%0d_sign", i), s4, tbl[i].sgn);
      check($sformatf("tbl%0d_ovw", i), o4, tbl[i].ov);
    end

    // Add latency and key dropped in the compute cycle.
    key(0, CLEAR); key(0, dg(2)); key(0, ADD); key(0, dg(3));
    @(negedge clk); drive(0, 1'b1, EQLS);
    @(negedge clk); drive(0, 1'b1, dg(9));
    check("add_compute_cycle_value", v4, 16'h0002);
    check("add_compute_cycle_busy", b4, 0);
    @(negedge clk); drive(0, 1'b0, 5'h00);
    check("add_latency_value", v4, 16'h0005);
    check("add_compute_drop", d4, 1);
    @(negedge clk);
    check("add_drop_pulse_end", d4, 0);
    check("add_drop_ignored", v4, 16'h0005);

    // Back-to-back strobes.
    key(0, CLEAR);
    @(negedge clk); drive(0, 1'b1, dg(1));
    @(negedge clk); drive(0, 1'b1, dg(2));
    check("b2b_first", v4, 16'h0001);
    @(negedge clk); drive(0, 1'b1, dg(3));
    check("b2b_second", v4, 16'h0012);
    @(negedge clk); drive(0, 1'b0, 5'h00);
    check("b2b_third", v4, 16'h0123);

    // Multiply overflow and busy length.
    key(0, CLEAR);
    for (int i = 0; i < 4; i++) key(0, dg(4'hF));
    key(0, MULT); key(0, dg(2));
    press(0, EQLS);
    n = 0;
    while (b4 && n < 100) begin n++; @(negedge clk); end
    check("mul_busy_cycles", n, 16);
    check("mul_ovf_value", v4, 16'hFFFE);
    check("mul_ovf_flag", o4, 1);
    check("mul_ovf_sign", s4, 0);
    @(negedge clk);
    key(0, dg(3));
    check("digit_after_ovf_value", v4, 16'h0003);
    check("digit_after_ovf_flag", o4, 0);

    // Key strobed while busy is dropped.
    key(0, CLEAR);
    key(0, dg(1)); key(0, dg(2)); key(0, dg(3)); key(0, dg(4));
    key(0, MULT); key(0, dg(3));
    press(0, EQLS);
    drops = 0; seen7 = 0;
    for (int i = 0; i < 40 && b4; i++) begin
      if (i == 3) drive(0, 1'b1, dg(7)); else drive(0, 1'b0, 5'h00);
      @(negedge clk);
      if (d4) drops++;
      if (v4 == 16'h0007) seen7++;
    end
    drive(0, 1'b0, 5'h00);
    repeat (2) begin
      @(negedge clk);
      if (d4) drops++;
      if (v4 == 16'h0007) seen7++;
    end
    check("busy_drop_count", drops, 1);
    check("busy_drop_no7", seen7, 0);
    check("busy_drop_value", v4, 16'h369C);
    check("busy_drop_sign", s4, 0);

    // Reset in the middle of a multiply.
    key(0, CLEAR);
    for (int i = 0; i < 4; i++) key(0, dg(4'hF));
    key(0, MULT); key(0, dg(4'hF));
    press(0, EQLS);
    repeat (4) @(negedge clk);
    check("pre_reset_busy", b4, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midreset_value", v4, 0);
    check("midreset_sign", s4, 0);
    check("midreset_ovw", o4, 0);
    check("midreset_busy", b4, 0);
    check("midreset_drop", d4, 0);
    repeat (20) @(negedge clk);
    check("midreset_no_late_result", v4, 0);
    key(0, dg(2));
    check("midreset_entry1", v4, 16'h0002);
    key(0, ADD); key(0, dg(2)); key(0, EQLS);
    check("midreset_2p2", v4, 16'h0004);

    // NDIG=6 instance.
    for (int i = 0; i < 6; i++) key(1, dg(4'hF));
    key(1, ADD); key(1, dg(1)); key(1, EQLS);
    check("n6_ovf_value", v6, 0);
    check("n6_ovf_flag", o6, 1);
    check("n6_ovf_sign", s6, 0);
    key(1, CLEAR);
    check("n6_clear_ovw", o6, 0);
    key(1, dg(3)); key(1, SUBT); key(1, dg(5)); key(1, SUBT);
    check("n6_chain_mid_value", v6, 24'h000002);
    check("n6_chain_mid_sign", s6, 1);
    key(1, dg(2)); key(1, EQLS);
    check("n6_chain_value", v6, 24'h000004);
    check("n6_chain_sign", s6, 1);

    // Random key stream against the model.
    key(0, CLEAR);
    m_clear();
    for (int i = 0; i < 400; i++) begin
      logic [4:0] k;
      k = rand_key();
      key(0, k);
      m_key(k);
      if (m_mode == M_E1 || m_mode == M_E2) begin ev = 16'(m_entry); es = 1'b0; end
      else begin ev = 16'(m_acc); es = m_acc_s; end
      check($sformatf("rnd%0d_k%02h_value", i, k), v4, ev);
      check($sformatf("rnd%0d_k%02h_sign", i, k), s4, es);
      check($sformatf("rnd%0d_k%02h_ovw", i, k), o4, m_ovw);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
